// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the jtkcpu bus controller: FSM encodings and the
// data value returned to the core when a ROM fetch times out.
package jtkcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TOUT_FILL = 8'hFF;

endpackage

// File: rtl/jtkcpu_fraccen.sv
// Fractional clock-enable generator for the jtkcpu core. Enables lost while
// dtack is low are counted and replayed later so the average rate holds.
module jtkcpu_fraccen #(
  parameter int NUM = 1,
  parameter int DEN = 4,
  parameter int CW  = 10,
  parameter int RW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dtack,
  output logic cen2
);

  localparam logic [CW:0]   NUM_W    = (CW+1)'(NUM);
  localparam logic [CW:0]   DEN_W    = (CW+1)'(DEN);
  localparam logic [RW-1:0] MISS_MAX = '1;

  logic [CW-1:0] acc_q, acc_d;
  logic [CW:0]   sum_s;
  logic          tick_s, recov_s;
  logic [RW-1:0] miss_q, miss_d;
  logic          cen_prev_q;

  // A replayed enable never follows an enable directly and never shares a tick cycle
  always_comb begin
    sum_s   = {1'b0, acc_q} + NUM_W;
    tick_s  = (sum_s >= DEN_W);
    if (tick_s) begin
      acc_d = CW'(sum_s - DEN_W);
    end else begin
      acc_d = sum_s[CW-1:0];
    end
    recov_s = !tick_s && dtack && (miss_q != '0) && !cen_prev_q;
    if (tick_s && !dtack && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + RW'(1);
    end else if (recov_s) begin
      miss_d = miss_q - RW'(1);
    end else begin
      miss_d = miss_q;
    end
  end

  assign cen2 = tick_s | recov_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      miss_q     <= '0;
      cen_prev_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      miss_q     <= miss_d;
      cen_prev_q <= cen2;
    end
  end

endmodule

// File: rtl/jtkcpu_busctl.sv
// Bus controller between the jtkcpu core and SDRAM-backed ROM: stalls the core
// with dtack while a ROM byte is fetched and keeps a one-byte hit cache.
module jtkcpu_busctl
  import jtkcpu_pkg::*;
#(
  parameter int NUM  = 1,
  parameter int DEN  = 4,
  parameter int CW   = 10,
  parameter int RW   = 4,
  parameter int TOUT = 255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        rom_cs,
  input  logic [7:0]  other_din,
  input  logic        rom_ok,
  input  logic [7:0]  rom_data,
  output logic        cen2,
  output logic        dtack,
  output logic [7:0]  cpu_din,
  output logic [23:0] rom_addr,
  output logic        rom_req,
  output logic        bus_err
);

  localparam int            TW    = $clog2(TOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

  state_t        state_q;
  logic [23:0]   rom_addr_q;
  logic          rom_req_q;
  logic [7:0]    dlatch_q;
  logic [23:0]   last_addr_q;
  logic          last_vld_q;
  logic          bus_err_q;
  logic [TW-1:0] tcnt_q;

  logic miss_s, addr_chg_s, dtack_s;

  // dtack drops in the very cycle a miss is seen so the core never latches stale data
  always_comb begin
    miss_s     = rom_cs && !cpu_we && (!last_vld_q || (cpu_addr != last_addr_q));
    addr_chg_s = rom_cs && !cpu_we && (cpu_addr != rom_addr_q);
    case (state_q)
      ST_IDLE: dtack_s = !miss_s;
      ST_WAIT: dtack_s = 1'b0;
      default: dtack_s = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= 24'h000000;
      rom_req_q   <= 1'b0;
      dlatch_q    <= 8'h00;
      last_addr_q <= 24'h000000;
      last_vld_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_s) begin
            state_q    <= ST_WAIT;
            rom_addr_q <= cpu_addr;
            rom_req_q  <= 1'b1;
            tcnt_q     <= '0;
          end
        end
        ST_WAIT: begin
          // A new address supersedes the outstanding fetch; rom_ok belongs to the old one
          if (addr_chg_s) begin
            rom_addr_q <= cpu_addr;
            tcnt_q     <= '0;
          end else if (rom_ok) begin
            state_q     <= ST_DONE;
            rom_req_q   <= 1'b0;
            dlatch_q    <= rom_data;
            last_addr_q <= rom_addr_q;
            last_vld_q  <= 1'b1;
          end else if (tcnt_q == TLAST) begin
            // The fill byte is not cached: a later read of this address fetches again
            state_q     <= ST_DONE;
            rom_req_q   <= 1'b0;
            dlatch_q    <= TOUT_FILL;
            last_addr_q <= rom_addr_q;
            last_vld_q  <= 1'b0;
            bus_err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        ST_DONE: begin
          if ((cpu_addr != last_addr_q) || !rom_cs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rom_req_q <= 1'b0;
        end
      endcase
    end
  end

  jtkcpu_fraccen #(
    .NUM (NUM),
    .DEN (DEN),
    .CW  (CW),
    .RW  (RW)
  ) u_fraccen (
    .clk   (clk),
    .rst   (rst),
    .dtack (dtack_s),
    .cen2  (cen2)
  );

  assign dtack    = dtack_s;
  assign cpu_din  = rom_cs ? dlatch_q : other_din;
  assign rom_addr = rom_addr_q;
  assign rom_req  = rom_req_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_jtkcpu_busctl.sv
// Directed self-checking bench for jtkcpu_busctl with default parameters
// (cen2 = clk/4, 255-cycle timeout).
module tb_jtkcpu_busctl;

  logic        rst, clk;
  logic [23:0] cpu_addr;
  logic        cpu_we, rom_cs, rom_ok;
  logic [7:0]  other_din, rom_data;
  logic        cen2, dtack, rom_req, bus_err;
  logic [7:0]  cpu_din;
  logic [23:0] rom_addr;

  int total = 0;
  int bad   = 0;

  jtkcpu_busctl dut (
    .rst       (rst),
    .clk       (clk),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .rom_cs    (rom_cs),
    .other_din (other_din),
    .rom_ok    (rom_ok),
    .rom_data  (rom_data),
    .cen2      (cen2),
    .dtack     (dtack),
    .cpu_din   (cpu_din),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_addr = 24'h000000; cpu_we = 1'b0; rom_cs = 1'b0;
    other_din = 8'h5A; rom_ok = 1'b0; rom_data = 8'h00;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    total++; if (cen2 !== 1'b0) begin bad++; $display("FAIL reset_cen2 got=%b exp=0", cen2); end
    total++; if (dtack !== 1'b1) begin bad++; $display("FAIL reset_dtack got=%b exp=1", dtack); end
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL reset_rom_req got=%b exp=0", rom_req); end
    total++; if (rom_addr !== 24'h000000) begin bad++; $display("FAIL reset_rom_addr got=%h exp=000000", rom_addr); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    total++; if (cpu_din !== 8'h5A) begin bad++; $display("FAIL reset_din_other got=%h exp=5a", cpu_din); end
    next_cycle; rom_cs = 1'b1; cpu_we = 1'b1;
    @(negedge clk);
    total++; if (cpu_din !== 8'h00) begin bad++; $display("FAIL reset_dlatch got=%h exp=00", cpu_din); end
    total++; if (dtack !== 1'b1) begin bad++; $display("FAIL reset_write_dtack got=%b exp=1", dtack); end
    next_cycle; rom_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_divider;
    int cnt = 0;
    int last = -1;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) next_cycle;
      @(negedge clk);
      total++; if (dtack !== 1'b1) begin bad++; $display("FAIL div_dtack cyc=%0d got=%b exp=1", k, dtack); end
      if (cen2 === 1'b1) begin
        cnt++;
        if (last >= 0) begin
          total++; if (k - last != 4) begin bad++; $display("FAIL div_spacing cyc=%0d got=%0d exp=4", k, k - last); end
        end
        last = k;
      end
    end
    total++; if (cnt != 100) begin bad++; $display("FAIL div_count got=%0d exp=100", cnt); end
  endtask

  task automatic test_rom_read;
    int lowcnt = 0;
    int req_at = -1;
    int pcnt = 0;
    bit released = 1'b0;
    next_cycle; cpu_addr = 24'h001234; rom_cs = 1'b1; cpu_we = 1'b0; rom_ok = 1'b0; rom_data = 8'h3C;
    for (int k = 0; k < 40 && !released; k++) begin
      if (k > 0) begin
        next_cycle;
        rom_ok   = (k == 7);
        rom_data = (k == 7) ? 8'hA5 : 8'h3C;
      end
      @(negedge clk);
      if (k == 0) begin
        total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL read_req_early got=%b exp=0", rom_req); end
      end
      if (rom_req === 1'b1 && req_at < 0) req_at = k;
      if (dtack === 1'b0) lowcnt++;
      else begin
        released = 1'b1;
        pcnt = (cen2 === 1'b1) ? 1 : 0;
        total++; if (dut.u_fraccen.miss_q !== 4'd2) begin bad++; $display("FAIL read_miss got=%0d exp=2", dut.u_fraccen.miss_q); end
      end
    end
    total++; if (!released) begin bad++; $display("FAIL read_release got=stuck exp=released"); end
    total++; if (req_at != 1) begin bad++; $display("FAIL read_req_rise got=%0d exp=1", req_at); end
    total++; if (lowcnt != 8) begin bad++; $display("FAIL read_wait_len got=%0d exp=8", lowcnt); end
    total++; if (cpu_din !== 8'hA5) begin bad++; $display("FAIL read_data got=%h exp=a5", cpu_din); end
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL read_req_drop got=%b exp=0", rom_req); end
    // 24 cycles hold 6 regular enables plus the 2 replayed ones
    for (int j = 1; j < 24; j++) begin
      next_cycle; rom_data = 8'h77;
      @(negedge clk);
      if (cen2 === 1'b1) pcnt++;
    end
    total++; if (pcnt != 8) begin bad++; $display("FAIL read_recovery got=%0d exp=8", pcnt); end
    total++; if (cpu_din !== 8'hA5) begin bad++; $display("FAIL read_data_hold got=%h exp=a5", cpu_din); end
  endtask

  task automatic test_hit_and_write;
    next_cycle; rom_cs = 1'b0; other_din = 8'hC3;
    @(negedge clk);
    total++; if (cpu_din !== 8'hC3) begin bad++; $display("FAIL mux_other got=%h exp=c3", cpu_din); end
    next_cycle; rom_cs = 1'b1; cpu_addr = 24'h001234; cpu_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle;
      @(negedge clk);
      total++; if (dtack !== 1'b1) begin bad++; $display("FAIL hit_dtack cyc=%0d got=%b exp=1", k, dtack); end
      total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL hit_req cyc=%0d got=%b exp=0", k, rom_req); end
      total++; if (cpu_din !== 8'hA5) begin bad++; $display("FAIL hit_data cyc=%0d got=%h exp=a5", k, cpu_din); end
    end
    next_cycle; cpu_addr = 24'h005555; cpu_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle;
      @(negedge clk);
      total++; if (dtack !== 1'b1) begin bad++; $display("FAIL write_dtack cyc=%0d got=%b exp=1", k, dtack); end
      total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL write_req cyc=%0d got=%b exp=0", k, rom_req); end
    end
    next_cycle; rom_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_timeout;
    int lowcnt = 0;
    bit released = 1'b0;
    next_cycle; cpu_addr = 24'h002000; rom_cs = 1'b1; cpu_we = 1'b0; rom_ok = 1'b0; rom_data = 8'h12;
    for (int k = 0; k < 400 && !released; k++) begin
      if (k > 0) next_cycle;
      @(negedge clk);
      if (k == 0) begin
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL tout_err_early got=%b exp=0", bus_err); end
      end
      if (dtack === 1'b0) lowcnt++; else released = 1'b1;
    end
    total++; if (!released) begin bad++; $display("FAIL tout_release got=stuck exp=released"); end
    total++; if (lowcnt != 256) begin bad++; $display("FAIL tout_wait_len got=%0d exp=256", lowcnt); end
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL tout_bus_err got=%b exp=1", bus_err); end
    total++; if (cpu_din !== 8'hFF) begin bad++; $display("FAIL tout_fill got=%h exp=ff", cpu_din); end
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL tout_req got=%b exp=0", rom_req); end
    next_cycle; rom_cs = 1'b0;
    next_cycle;
    @(negedge clk);
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL tout_sticky got=%b exp=1", bus_err); end
  endtask

  task automatic test_reset_in_wait;
    next_cycle; cpu_addr = 24'h003000; rom_cs = 1'b1; cpu_we = 1'b0;
    next_cycle;
    next_cycle;
    @(negedge clk);
    total++; if (dtack !== 1'b0) begin bad++; $display("FAIL rstw_pre_dtack got=%b exp=0", dtack); end
    total++; if (rom_req !== 1'b1) begin bad++; $display("FAIL rstw_pre_req got=%b exp=1", rom_req); end
    next_cycle; rst = 1'b1; rom_cs = 1'b0;
    next_cycle; rst = 1'b0;
    @(negedge clk);
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL rstw_state got=%0d exp=0", dut.state_q); end
    total++; if (dtack !== 1'b1) begin bad++; $display("FAIL rstw_dtack got=%b exp=1", dtack); end
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL rstw_req got=%b exp=0", rom_req); end
    total++; if (dut.u_fraccen.miss_q !== 4'd0) begin bad++; $display("FAIL rstw_miss got=%0d exp=0", dut.u_fraccen.miss_q); end
    total++; if (dut.last_vld_q !== 1'b0) begin bad++; $display("FAIL rstw_last_vld got=%b exp=0", dut.last_vld_q); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rstw_bus_err got=%b exp=0", bus_err); end
  endtask

  task automatic test_addr_change;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle;
      case (c)
        0: begin cpu_addr = 24'h000010; rom_cs = 1'b1; cpu_we = 1'b0; rom_ok = 1'b0; rom_data = 8'h00; end
        4: begin cpu_addr = 24'h000020; rom_ok = 1'b1; rom_data = 8'h11; end
        5: begin rom_ok = 1'b0; rom_data = 8'h00; end
        7: begin rom_ok = 1'b1; rom_data = 8'h22; end
        8: begin rom_ok = 1'b0; rom_data = 8'h99; end
        default: ;
      endcase
      @(negedge clk);
      if (c == 1) begin
        total++; if (rom_addr !== 24'h000010) begin bad++; $display("FAIL chg_addr_first got=%h exp=000010", rom_addr); end
      end
      if (c >= 1 && c <= 7) begin
        total++; if (rom_req !== 1'b1) begin bad++; $display("FAIL chg_req cyc=%0d got=%b exp=1", c, rom_req); end
        total++; if (dtack !== 1'b0) begin bad++; $display("FAIL chg_dtack cyc=%0d got=%b exp=0", c, dtack); end
      end
      if (c == 5 || c == 7) begin
        total++; if (rom_addr !== 24'h000020) begin bad++; $display("FAIL chg_addr_new cyc=%0d got=%h exp=000020", c, rom_addr); end
      end
      if (c == 8) begin
        total++; if (dtack !== 1'b1) begin bad++; $display("FAIL chg_release got=%b exp=1", dtack); end
        total++; if (cpu_din !== 8'h22) begin bad++; $display("FAIL chg_data got=%h exp=22", cpu_din); end
        total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL chg_req_drop got=%b exp=0", rom_req); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_divider;
    test_rom_read;
    test_hit_and_write;
    test_timeout;
    test_reset_in_wait;
    test_addr_change;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
